// File: rtl/lsu_ctrl.sv
// Load/store unit: turns an ALU effective address plus rs2/funct3 into a single
// data-memory handshake with byte lanes, then returns extended load data.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [3:0]        mem_be_o,
  output logic [31:0]       mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [31:0]       mem_rdata_i,
  output logic              rsp_valid_o,
  output logic [31:0]       rsp_data_o,
  output logic              rsp_err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_RESP,
    S_ERR
  } state_t;

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [31:0] rsp_data_q;

  logic        legal;
  logic        aligned;
  logic        accept;
  logic        hit_limit;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;
  logic [31:0] rd_shifted;
  logic [31:0] rd_ext;

  // Request decode: legality, alignment and lane placement from the raw request.
  always_comb begin
    legal = 1'b0;
    if (req_we_i) begin
      legal = (req_funct3_i == 3'b000) || (req_funct3_i == 3'b001) ||
              (req_funct3_i == 3'b010);
    end else begin
      legal = (req_funct3_i == 3'b000) || (req_funct3_i == 3'b001) ||
              (req_funct3_i == 3'b010) || (req_funct3_i == 3'b100) ||
              (req_funct3_i == 3'b101);
    end

    aligned = 1'b1;
    if (req_funct3_i[1:0] == 2'b01) begin
      aligned = ~req_addr_i[0];
    end else if (req_funct3_i[1:0] == 2'b10) begin
      aligned = (req_addr_i[1:0] == 2'b00);
    end

    be_calc    = 4'b1111;
    wdata_calc = req_wdata_i;
    case (req_funct3_i[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << req_addr_i[1:0];
        wdata_calc = {4{req_wdata_i[7:0]}};
      end
      2'b01: begin
        be_calc    = req_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{req_wdata_i[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = req_wdata_i;
      end
    endcase
  end

  // Halfwords are always even-aligned here, so a byte-granular shift covers both sizes.
  always_comb begin
    rd_shifted = mem_rdata_i >> {off_q, 3'b000};
    case (funct3_q)
      3'b000:  rd_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      3'b100:  rd_ext = {24'd0, rd_shifted[7:0]};
      3'b001:  rd_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      3'b101:  rd_ext = {16'd0, rd_shifted[15:0]};
      default: rd_ext = rd_shifted;
    endcase
  end

  assign accept    = (state == S_IDLE) && req_valid_i;
  assign hit_limit = (cnt == 8'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (req_valid_i) begin
          state_nxt = (legal && aligned) ? S_BUSY : S_ERR;
        end
      end
      S_BUSY: begin
        if (mem_ack_i) begin
          state_nxt = S_RESP;
        end else if (hit_limit) begin
          state_nxt = S_ERR;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt         <= '0;
      we_q        <= 1'b0;
      funct3_q    <= '0;
      off_q       <= '0;
      rsp_data_q  <= '0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_be_o    <= '0;
      mem_wdata_o <= '0;
    end else begin
      if (accept && legal && aligned) begin
        cnt         <= '0;
        we_q        <= req_we_i;
        funct3_q    <= req_funct3_i;
        off_q       <= req_addr_i[1:0];
        rsp_data_q  <= '0;
        mem_we_o    <= req_we_i;
        mem_addr_o  <= {req_addr_i[ADDR_W-1:2], 2'b00};
        mem_be_o    <= be_calc;
        mem_wdata_o <= wdata_calc;
      end else if (state == S_BUSY) begin
        if (mem_ack_i) begin
          rsp_data_q <= we_q ? '0 : rd_ext;
          mem_we_o   <= 1'b0;
          mem_be_o   <= '0;
        end else if (hit_limit) begin
          mem_we_o <= 1'b0;
          mem_be_o <= '0;
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

  // Handshake outputs decode straight from state so an async reset drops them at once.
  assign req_ready_o = (state == S_IDLE) && !rst_i;
  assign mem_req_o   = (state == S_BUSY);
  assign rsp_valid_o = (state == S_RESP) || (state == S_ERR);
  assign rsp_err_o   = (state == S_ERR);
  assign rsp_data_o  = (state == S_RESP) ? rsp_data_q : '0;

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
Load/store unit directly downstream of the ALU. It takes the effective address from the ALU result (alu_data_o of an ADD) together with rs2 data and funct3. It drives a single-port data-memory handshake with byte enables, then returns sign- or zero-extended load data to writeback. The block is multi-cycle, with a request/response handshake toward the core, misalignment and illegal-funct3 detection, and an ack timeout.

Parameters:
TIMEOUT_CYCLES, 255, max cycles in BUSY without mem_ack_i before abort (1..255)
ADDR_W, 32, address width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  asynchronous, active-high reset
req_valid_i  in  1  core presents a memory op
req_ready_o  out  1  LSU can accept (high only in IDLE)
req_we_i  in  1  1=store, 0=load
req_funct3_i  in  3  RV32I width/sign code
req_addr_i  in  ADDR_W  effective address from ALU
req_wdata_i  in  32  store data (rs2)
mem_req_o  out  1  memory request strobe
mem_we_o  out  1  memory write enable
mem_addr_o  out  ADDR_W  word-aligned address ({addr[31:2],2'b00})
mem_be_o  out  4  byte enables
mem_wdata_o  out  32  lane-shifted store data
mem_ack_i  in  1  memory completion
mem_rdata_i  in  32  memory read word, valid with mem_ack_i
rsp_valid_o  out  1  one-cycle response pulse
rsp_data_o  out  32  extended load data (0 for stores/errors)
rsp_err_o  out  1  misaligned, illegal or timeout; valid with rsp_valid_o

Behaviour:
- States: IDLE, BUSY, RESP, ERR. Reset puts the FSM in IDLE.
- Reset values: all outputs 0, including req_ready_o while rst_i is high. Timeout counter is 0.
- Reset mid-operation drops mem_req_o immediately (async) and discards the pending op. No response is produced.
- IDLE: req_ready_o=1. On req_valid_i, the block latches we, funct3 and addr[1:0]. It computes mem_addr/be/wdata into output registers.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Legal stores: 000 SB, 001 SH, 010 SW. Any other code is illegal.
- Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
- Illegal or misaligned requests go to ERR. No memory access is made and mem_req_o stays 0.
- Legal requests go to BUSY. The counter clears and mem_req_o=1 from the next cycle.
- Store lanes:
  - SB: be=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
  - SH: be = addr[1] ? 4'b1100 : 4'b0011, wdata={2{wdata[15:0]}}.
  - SW: be=4'b1111, wdata=wdata.
- Loads: mem_be_o uses the same lane rule and mem_we_o=0.
- BUSY:
  - mem_req_o, mem_we_o, mem_addr_o, mem_be_o and mem_wdata_o are held stable until ack.
  - On mem_ack_i, a load captures mem_rdata_i. The selected lane is shifted right by 8*addr[1:0] (halfwords by 16*addr[1]) and sign- or zero-extended. The FSM goes to RESP.
  - mem_req_o deasserts in the cycle after ack.
  - Each cycle without ack increments the counter. If the counter reaches TIMEOUT_CYCLES without ack, mem_req_o drops and the FSM goes to ERR.
  - An ack arriving in the same cycle the counter hits the limit wins: the FSM goes to RESP.
- RESP: rsp_valid_o=1 for exactly one cycle with rsp_err_o=0. rsp_data_o holds the extended load data, or 0 for a store. Next state is IDLE.
- ERR: rsp_valid_o=1 and rsp_err_o=1 for one cycle, rsp_data_o=0. Next state is IDLE.
- mem_ack_i in IDLE, RESP or ERR is ignored.
- req_valid_i outside IDLE is not accepted (req_ready_o=0). The core must hold the request.
- Latency: accept at cycle 0, mem_req_o high from cycle 1. An ack at cycle k gives rsp_valid_o at cycle k+1, so the minimum is 2 cycles. Error responses arrive at cycle 1.
- Back-to-back: a new request can be accepted in the cycle after the response pulse (IDLE).

Test Plan:
- LB at addr 0x1003, rdata=0x80FF_1234, ack on first req cycle -> mem_addr_o=0x1000, be=4'b1000, rsp_data_o=0xFFFF_FF80 at cycle 2, err=0.
- LHU at 0x2002, rdata=0x9ABC_5678 -> be=4'b1100, rsp_data_o=0x0000_9ABC. The same access as LH gives 0xFFFF_9ABC.
- SB at 0x3001, wdata=0x1122_33A5 -> mem_we_o=1, be=4'b0010, mem_wdata_o=0xA5A5_A5A5, rsp_data_o=0. mem_req_o is held through a 3-cycle ack delay.
- LW at 0x4002 and funct3=3'b011 -> no mem_req_o, rsp_valid_o and rsp_err_o at cycle 1, rsp_data_o=0.
- SW with no ack, TIMEOUT_CYCLES=4 -> mem_req_o high for 4 cycles, then an ERR pulse. An ack arriving on the 4th cycle instead yields a normal RESP.
- rst_i asserted mid-BUSY -> mem_req_o=0 immediately, no rsp_valid_o. After release, req_ready_o=1 and a new LW at 0x0 completes normally.
